// File: rtl/axis_ema_arb2.sv
// axis_ema_arb2: two-input AXI-Stream packet scheduler sharing one EMA
// datapath (y = x/4 + 3y/4) with a separate filter state per channel.
// Packets are granted whole and round-robin on ties; the merged output
// carries the source channel in M_AXIS_TID.
// Optional feature macro: EMA_CLEAR_ON_LAST_EN -- when defined, a channel's
// filter state returns to INIT_VAL after each accepted TLAST beat.
module axis_ema_arb2 #(
   parameter int DATA_W   = 32,
   parameter int INIT_VAL = 1000
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [DATA_W-1:0]     S0_AXIS_TDATA,
   input  logic [DATA_W/8-1:0]   S0_AXIS_TKEEP,
   input  logic                  S0_AXIS_TLAST,
   input  logic                  S0_AXIS_TVALID,
   output logic                  S0_AXIS_TREADY,
   input  logic [DATA_W-1:0]     S1_AXIS_TDATA,
   input  logic [DATA_W/8-1:0]   S1_AXIS_TKEEP,
   input  logic                  S1_AXIS_TLAST,
   input  logic                  S1_AXIS_TVALID,
   output logic                  S1_AXIS_TREADY,
   output logic [DATA_W-1:0]     M_AXIS_TDATA,
   output logic [DATA_W/8-1:0]   M_AXIS_TKEEP,
   output logic                  M_AXIS_TLAST,
   output logic                  M_AXIS_TID,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam logic [DATA_W-1:0] INIT_STATE = DATA_W'(INIT_VAL);

   logic [1:0]          state;
   logic                last_gnt;
   logic [DATA_W-1:0]   prev0;
   logic [DATA_W-1:0]   prev1;

   logic                out_free;
   logic                acc0;
   logic                acc1;
   logic                acc;
   logic [DATA_W-1:0]   sel_x;
   logic [DATA_W/8-1:0] sel_keep;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_prev;
   logic [DATA_W-1:0]   y;
   logic [DATA_W-1:0]   prev_upd;

   // Handshake, channel mux and the shared EMA datapath.
   always_comb begin
      out_free       = !M_AXIS_TVALID || M_AXIS_TREADY;
      S0_AXIS_TREADY = (state == GNT0) && out_free;
      S1_AXIS_TREADY = (state == GNT1) && out_free;
      acc0           = S0_AXIS_TVALID && S0_AXIS_TREADY;
      acc1           = S1_AXIS_TVALID && S1_AXIS_TREADY;
      acc            = acc0 || acc1;
      sel_x          = acc1 ? S1_AXIS_TDATA : S0_AXIS_TDATA;
      sel_keep       = acc1 ? S1_AXIS_TKEEP : S0_AXIS_TKEEP;
      sel_last       = acc1 ? S1_AXIS_TLAST : S0_AXIS_TLAST;
      sel_prev       = acc1 ? prev1 : prev0;
      // Each shift truncates on its own, so 3y/4 is built as y/4 + y/2.
      y              = (sel_x >> 2) + (sel_prev >> 2) + (sel_prev >> 1);
`ifdef EMA_CLEAR_ON_LAST_EN
      prev_upd       = sel_last ? INIT_STATE : y;
`else
      prev_upd       = y;
`endif
   end

   // Packet arbiter: registered grant decision, released only on TLAST.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
                  state    <= last_gnt ? GNT0 : GNT1;
                  last_gnt <= !last_gnt;
               end else if (S0_AXIS_TVALID) begin
                  state <= GNT0;
               end else if (S1_AXIS_TVALID) begin
                  state <= GNT1;
               end
            end
            GNT0:    if (acc0 && S0_AXIS_TLAST) state <= IDLE;
            GNT1:    if (acc1 && S1_AXIS_TLAST) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Per-channel filter state; only the accepting channel advances.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         prev0 <= INIT_STATE;
         prev1 <= INIT_STATE;
      end else begin
         if (acc0) prev0 <= prev_upd;
         if (acc1) prev1 <= prev_upd;
      end
   end

   // Output register: load on accept, clear on drain, hold under backpressure.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TKEEP  <= '0;
         M_AXIS_TLAST  <= 1'b0;
         M_AXIS_TID    <= 1'b0;
      end else if (acc) begin
         M_AXIS_TVALID <= 1'b1;
         M_AXIS_TDATA  <= y;
         M_AXIS_TKEEP  <= sel_keep;
         M_AXIS_TLAST  <= sel_last;
         M_AXIS_TID    <= acc1;
      end else if (M_AXIS_TREADY) begin
         M_AXIS_TVALID <= 1'b0;
      end
   end

endmodule

// File: doc/axis_ema_arb2.md
# axis_ema_arb2

Two-input AXI-Stream scheduler that time-shares a single EMA datapath (y = x/4 + 3y/4) between two independent source streams. It grants whole packets, round-robin at TLAST boundaries, and keeps a separate filter state per channel. The merged output carries a source tag. It sits between two DMA/source streams and the single downstream M_AXIS consumer.

## Interface
- DATA_W, 32, data width of all TDATA buses and filter state
- INIT_VAL, 1000, per-channel filter state after reset
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- S0_AXIS_TDATA / S1_AXIS_TDATA  in  DATA_W  sample input, channel 0 / 1
- S0_AXIS_TKEEP / S1_AXIS_TKEEP  in  DATA_W/8  byte keep
- S0_AXIS_TLAST / S1_AXIS_TLAST  in  1  end of packet
- S0_AXIS_TVALID / S1_AXIS_TVALID  in  1  beat valid
- S0_AXIS_TREADY / S1_AXIS_TREADY  out  1  beat accepted when TVALID&&TREADY
- M_AXIS_TDATA  out  DATA_W  filtered output
- M_AXIS_TKEEP  out  DATA_W/8  registered copy of accepted TKEEP
- M_AXIS_TLAST  out  1  registered copy of accepted TLAST
- M_AXIS_TID  out  1  source channel of current output beat
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  downstream ready

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset → IDLE.
- IDLE: all S_TREADY=0. If exactly one S_TVALID is high, go to that channel's GNT state. If both are high, grant the channel opposite to last_gnt, then update last_gnt. Reset value of last_gnt is 1, so channel 0 wins the first tie.
- GNTc: S_c_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY. The other channel's TREADY stays 0.
- GNTc exit: when a beat with TLAST=1 is accepted on channel c, go to IDLE. No preemption mid-packet.
- Filter: state regs prev0, prev1 (DATA_W each). On an accepted beat from channel c: y = (x>>2) + (prev_c>>2) + (prev_c>>1). Each shift truncates; the sum is mod 2^DATA_W. Then prev_c ← y. The other channel's state is untouched.
- Output register: on accept, load M_TDATA←y, M_TKEEP, M_TLAST, M_TID←c, and set M_TVALID←1.
- If M_TVALID && M_TREADY with no new accept, clear M_TVALID.
- If accept and drain happen in the same cycle, the register reloads and M_TVALID stays 1.
- Output fields hold stable while M_TVALID && !M_TREADY.
- Reset values:
  - M_TVALID, M_TLAST, M_TID, M_TDATA, M_TKEEP = 0
  - S0/S1_TREADY = 0
  - prev0 = prev1 = INIT_VAL
  - state = IDLE, last_gnt = 1
- Reset mid-packet: the packet is abandoned, the output beat in the register is dropped, and both filter states revert to INIT_VAL.

## Timing
- Latency: input accept at edge N → M_AXIS_TVALID high after edge N (one register stage).
- Arbitration bubble: one cycle in IDLE between packets (decision registered). The first beat of a packet can be accepted no earlier than the cycle after TVALID is sampled in IDLE.
- Throughput inside a packet: one beat per cycle while M_AXIS_TREADY=1.
- Backpressure: M_AXIS_TREADY low with M_TVALID high forces the granted S_TREADY low in the same cycle (combinational path from M_AXIS_TREADY).
- TVALID deasserting mid-packet on the granted channel: grant is held and no switch occurs until TLAST.

## Configuration
- EMA_CLEAR_ON_LAST_EN defined: after an accepted TLAST beat on channel c, prev_c ← INIT_VAL instead of y. Each packet filters from a fresh state; the output beat still carries y.
- Undefined: prev_c ← y on every beat; filter state persists across packets.

## Test plan
- Reset, then ch0 single beat 2000, TLAST=1, M_TREADY=1 → one output beat: TDATA=1250, TID=0, TLAST=1; FSM back in IDLE.
- Both channels valid after reset, each with a 1-beat packet of 2000 → ch0 output 1250 (TID=0) first, then ch1 output 1250 (TID=1), confirming independent state. A second tie grants ch1 first.
- Ch0 two-beat packet 2000, 2000 (macro undefined) → outputs 1250, then 1437 ((500+312+625)). A following 1-beat ch0 packet of 2000 gives 1577 (500+359+718).
- Same sequence with EMA_CLEAR_ON_LAST_EN → outputs 1250, 1437; next packet's 2000 gives 1250.
- Hold M_AXIS_TREADY=0 for 3 cycles mid-packet → M_TDATA/TID/TLAST stable, S0_TREADY=0. No beat lost or duplicated; the sequence resumes in order.
- Assert ARESETN=0 asynchronously mid-packet (between edges) → M_TVALID and all TREADY drop immediately. After release, ch0 beat 2000 again yields 1250.
